// File: rtl/pooled_output_writer.sv
// pooled_output_writer: packs the tagged 8-bit pooled stream into SRAM words for two
// independent output regions and flushes partially filled words at end of layer.
//
// Ports
//   clk                 rising-edge clock
//   reset_b             asynchronous active-low reset
//   dut_run             level start request, sampled in IDLE
//   valid_in[1:0]       0 idle, 1 byte -> region 0, 2 byte -> region 1, 3 end of layer
//   pooled_data[7:0]    pooled byte, stored raw
//   sram_write_enable   one-cycle write strobe
//   sram_write_address  word address of the write
//   sram_write_data     packed word, byte k in bits [8k+7:8k]
//   dut_busy            high while a layer is in progress (RUN/FLUSH0/FLUSH1)
//   dut_done            one-cycle pulse once the layer is fully written
//   overflow_err        sticky, set when a region write index reaches REGION_WORDS
module pooled_output_writer #(
   parameter int unsigned BYTES_PER_WORD = 4,
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned BASE_ADDR_0    = 0,
   parameter int unsigned BASE_ADDR_1    = 256,
   parameter int unsigned REGION_WORDS   = 256
) (
   input  logic                        clk,
   input  logic                        reset_b,
   input  logic                        dut_run,
   input  logic [1:0]                  valid_in,
   input  logic [7:0]                  pooled_data,
   output logic                        sram_write_enable,
   output logic [ADDR_W-1:0]           sram_write_address,
   output logic [8*BYTES_PER_WORD-1:0] sram_write_data,
   output logic                        dut_busy,
   output logic                        dut_done,
   output logic                        overflow_err
);

   localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
   localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD + 1);

   localparam logic [1:0] V_IDLE = 2'd0;
   localparam logic [1:0] V_R1   = 2'd2;
   localparam logic [1:0] V_EOL  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH0,
      S_FLUSH1,
      S_DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [1:0][WORD_W-1:0]        buf_q, buf_d;
   logic [1:0][CNT_W-1:0]         cnt_q, cnt_d;
   logic [1:0][ADDR_W-1:0]        wcnt_q, wcnt_d;

   logic                          we_d;
   logic [ADDR_W-1:0]             addr_d;
   logic [WORD_W-1:0]             data_d;
   logic                          busy_d;
   logic                          done_d;
   logic                          ovf_d;

   logic                          wr_req;
   logic                          wr_reg;
   logic [WORD_W-1:0]             wr_word;
   logic                          sel;
   logic [WORD_W-1:0]             new_word;

   // Next-state and next-output logic. Outputs are computed for the state being entered,
   // so a write strobe is visible in the cycle after the byte (or flush state) that caused it.
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      wcnt_d   = wcnt_q;
      we_d     = 1'b0;
      addr_d   = sram_write_address;
      data_d   = sram_write_data;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      ovf_d    = overflow_err;
      wr_req   = 1'b0;
      wr_reg   = 1'b0;
      wr_word  = '0;
      sel      = 1'b0;
      new_word = '0;

      case (state_q)
         S_IDLE: begin
            if (dut_run) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               buf_d   = '0;
               cnt_d   = '0;
               wcnt_d  = '0;
               ovf_d   = 1'b0;
            end
         end

         S_RUN: begin
            busy_d = 1'b1;
            if (valid_in == V_EOL) begin
               // Region 0 partial word goes out as FLUSH0 is entered.
               state_d = S_FLUSH0;
               if (cnt_q[0] != '0) begin
                  wr_req  = 1'b1;
                  wr_reg  = 1'b0;
                  wr_word = buf_q[0];
               end
               buf_d[0] = '0;
               cnt_d[0] = '0;
            end else if (valid_in != V_IDLE) begin
               sel      = (valid_in == V_R1);
               new_word = buf_q[sel];
               for (int k = 0; k < BYTES_PER_WORD; k++) begin
                  if (cnt_q[sel] == CNT_W'(k)) begin
                     new_word[8*k +: 8] = pooled_data;
                  end
               end
               if (cnt_q[sel] == CNT_W'(BYTES_PER_WORD - 1)) begin
                  wr_req     = 1'b1;
                  wr_reg     = sel;
                  wr_word    = new_word;
                  buf_d[sel] = '0;
                  cnt_d[sel] = '0;
               end else begin
                  buf_d[sel] = new_word;
                  cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
               end
            end
         end

         S_FLUSH0: begin
            // Region 1 partial word goes out as FLUSH1 is entered.
            state_d = S_FLUSH1;
            busy_d  = 1'b1;
            if (cnt_q[1] != '0) begin
               wr_req  = 1'b1;
               wr_reg  = 1'b1;
               wr_word = buf_q[1];
            end
            buf_d[1] = '0;
            cnt_d[1] = '0;
         end

         S_FLUSH1: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Shared write port: at most one word completes per cycle.
      if (wr_req) begin
         we_d   = 1'b1;
         addr_d = (wr_reg ? ADDR_W'(BASE_ADDR_1) : ADDR_W'(BASE_ADDR_0)) + wcnt_q[wr_reg];
         data_d = wr_word;
         wcnt_d[wr_reg] = wcnt_q[wr_reg] + ADDR_W'(1);
         if (32'(wcnt_q[wr_reg]) >= REGION_WORDS) begin
            ovf_d = 1'b1;
         end
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q            <= S_IDLE;
         buf_q              <= '0;
         cnt_q              <= '0;
         wcnt_q             <= '0;
         sram_write_enable  <= 1'b0;
         sram_write_address <= '0;
         sram_write_data    <= '0;
         dut_busy           <= 1'b0;
         dut_done           <= 1'b0;
         overflow_err       <= 1'b0;
      end else begin
         state_q            <= state_d;
         buf_q              <= buf_d;
         cnt_q              <= cnt_d;
         wcnt_q             <= wcnt_d;
         sram_write_enable  <= we_d;
         sram_write_address <= addr_d;
         sram_write_data    <= data_d;
         dut_busy           <= busy_d;
         dut_done           <= done_d;
         overflow_err       <= ovf_d;
      end
   end

endmodule

// File: tb/tb_pooled_output_writer.sv
// Testbench for pooled_output_writer: directed table, reset and overflow sequences, and
// randomized layers checked against a byte-queue reference model.
module tb_pooled_output_writer;

   localparam int unsigned B0       = 0;
   localparam int unsigned B1       = 256;
   localparam int unsigned RW_MAIN  = 256;
   localparam int unsigned RW_SMALL = 2;

   logic        clk = 1'b0;
   logic        reset_b = 1'b0;
   logic        dut_run = 1'b0;
   logic [1:0]  valid_in = 2'd0;
   logic [7:0]  pooled_data = 8'h00;

   logic        m_we, m_busy, m_done, m_ovf;
   logic [11:0] m_addr;
   logic [31:0] m_data;
   logic        s_we, s_busy, s_done, s_ovf;
   logic [11:0] s_addr;
   logic [31:0] s_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pooled_output_writer dut (
      .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .valid_in(valid_in),
      .pooled_data(pooled_data), .sram_write_enable(m_we), .sram_write_address(m_addr),
      .sram_write_data(m_data), .dut_busy(m_busy), .dut_done(m_done), .overflow_err(m_ovf)
   );

   pooled_output_writer #(.REGION_WORDS(RW_SMALL)) dut_small (
      .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .valid_in(valid_in),
      .pooled_data(pooled_data), .sram_write_enable(s_we), .sram_write_address(s_addr),
      .sram_write_data(s_data), .dut_busy(s_busy), .dut_done(s_done), .overflow_err(s_ovf)
   );

   typedef struct {
      logic        run;
      logic [1:0]  valid;
      logic [7:0]  data;
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        busy;
      logic        done;
      logic        ovf;
      logic        ovf2;
   } vec_t;

   vec_t tbl[$];
   vec_t vecs[$];

   // Reference model state for one layer.
   logic [7:0]  m_q0[$];
   logic [7:0]  m_q1[$];
   int unsigned m_words[2];
   logic        m_ovf_a, m_ovf_b;

   function automatic vec_t mk(input logic run, input logic [1:0] valid, input logic [7:0] data,
                               input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                               input logic busy, input logic done);
      vec_t v;
      v.run = run; v.valid = valid; v.data = data; v.we = we; v.addr = addr;
      v.wdata = wdata; v.busy = busy; v.done = done; v.ovf = 1'b0; v.ovf2 = 1'b0;
      return v;
   endfunction

   function automatic vec_t run_();
      return mk(1'b1, 2'd0, 8'h00, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0);
   endfunction
   function automatic vec_t in_(input logic [1:0] v, input logic [7:0] d);
      return mk(1'b0, v, d, 1'b0, 12'd0, 32'h0, 1'b1, 1'b0);
   endfunction
   function automatic vec_t wr_(input logic [1:0] v, input logic [7:0] d, input logic [11:0] a,
                                input logic [31:0] w);
      return mk(1'b0, v, d, 1'b1, a, w, 1'b1, 1'b0);
   endfunction
   function automatic vec_t done_(input logic [1:0] v, input logic [7:0] d);
      return mk(1'b0, v, d, 1'b0, 12'd0, 32'h0, 1'b0, 1'b1);
   endfunction
   function automatic vec_t idle_(input logic [1:0] v, input logic [7:0] d);
      return mk(1'b0, v, d, 1'b0, 12'd0, 32'h0, 1'b0, 1'b0);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input string tag);
      dut_run     = v.run;
      valid_in    = v.valid;
      pooled_data = v.data;
      step();
      check({tag, " we"},   64'(m_we),   64'(v.we));
      if (v.we) begin
         check({tag, " addr"}, 64'(m_addr), 64'(v.addr));
         check({tag, " data"}, 64'(m_data), 64'(v.wdata));
         check({tag, " small addr"}, 64'(s_addr), 64'(v.addr));
         check({tag, " small data"}, 64'(s_data), 64'(v.wdata));
      end
      check({tag, " busy"}, 64'(m_busy), 64'(v.busy));
      check({tag, " done"}, 64'(m_done), 64'(v.done));
      check({tag, " ovf"},  64'(m_ovf),  64'(v.ovf));
      check({tag, " small we"},   64'(s_we),   64'(v.we));
      check({tag, " small busy"}, 64'(s_busy), 64'(v.busy));
      check({tag, " small done"}, 64'(s_done), 64'(v.done));
      check({tag, " small ovf"},  64'(s_ovf),  64'(v.ovf2));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " we"},   64'(m_we),   64'd0);
      check({tag, " addr"}, 64'(m_addr), 64'd0);
      check({tag, " data"}, 64'(m_data), 64'd0);
      check({tag, " busy"}, 64'(m_busy), 64'd0);
      check({tag, " done"}, 64'(m_done), 64'd0);
      check({tag, " ovf"},  64'(m_ovf),  64'd0);
      check({tag, " small ovf"}, 64'(s_ovf), 64'd0);
   endtask

   function automatic logic [31:0] pack(input logic [7:0] b[$]);
      logic [31:0] w = '0;
      for (int k = 0; k < b.size(); k++) w[8*k +: 8] = b[k];
      return w;
   endfunction

   task automatic m_write(input int r, input logic [31:0] d, inout vec_t v);
      v.we    = 1'b1;
      v.addr  = 12'((r == 1 ? B1 : B0) + m_words[r]);
      v.wdata = d;
      if (m_words[r] >= RW_MAIN)  m_ovf_a = 1'b1;
      if (m_words[r] >= RW_SMALL) m_ovf_b = 1'b1;
      m_words[r]++;
   endtask

   // Builds one random layer (start, n RUN cycles, end code, flush/done tail) into vecs.
   task automatic gen_layer(input int n, input int p_r0);
      vec_t v;
      int   pick;
      logic [1:0] code;
      m_q0.delete(); m_q1.delete();
      m_words[0] = 0; m_words[1] = 0;
      m_ovf_a = 1'b0; m_ovf_b = 1'b0;
      v = run_();
      v.valid = 2'($urandom_range(0, 3));
      v.data  = 8'($urandom);
      vecs.push_back(v);
      for (int i = 0; i < n; i++) begin
         pick = $urandom_range(0, 99);
         code = (pick < p_r0) ? 2'd1 : ((pick < p_r0 + (100 - p_r0) / 2) ? 2'd2 : 2'd0);
         v = in_(code, 8'($urandom));
         v.run = 1'($urandom);
         if (code == 2'd1) begin
            m_q0.push_back(v.data);
            if (m_q0.size() == 4) begin
               m_write(0, pack(m_q0), v);
               m_q0.delete();
            end
         end else if (code == 2'd2) begin
            m_q1.push_back(v.data);
            if (m_q1.size() == 4) begin
               m_write(1, pack(m_q1), v);
               m_q1.delete();
            end
         end
         v.ovf = m_ovf_a; v.ovf2 = m_ovf_b;
         vecs.push_back(v);
      end
      v = in_(2'd3, 8'($urandom));
      if (m_q0.size() > 0) m_write(0, pack(m_q0), v);
      v.ovf = m_ovf_a; v.ovf2 = m_ovf_b;
      vecs.push_back(v);
      v = in_(2'($urandom_range(0, 3)), 8'($urandom));
      v.run = 1'($urandom);
      if (m_q1.size() > 0) m_write(1, pack(m_q1), v);
      v.ovf = m_ovf_a; v.ovf2 = m_ovf_b;
      vecs.push_back(v);
      v = done_(2'($urandom_range(0, 3)), 8'($urandom));
      v.run = 1'($urandom);
      v.ovf = m_ovf_a; v.ovf2 = m_ovf_b;
      vecs.push_back(v);
      v = idle_(2'($urandom_range(0, 3)), 8'($urandom));
      v.run = 1'($urandom);
      v.ovf = m_ovf_a; v.ovf2 = m_ovf_b;
      vecs.push_back(v);
   endtask

   initial begin
      vec_t v;

      // Directed table: single-word pack, interleaving, flush, empty layer.
      tbl.push_back(run_());
      tbl.push_back(in_(2'd1, 8'h01));
      tbl.push_back(in_(2'd1, 8'h02));
      tbl.push_back(in_(2'd1, 8'h03));
      tbl.push_back(wr_(2'd1, 8'h04, 12'd0, 32'h04030201));
      tbl.push_back(in_(2'd3, 8'h00));
      tbl.push_back(in_(2'd0, 8'h00));
      tbl.push_back(done_(2'd0, 8'h00));
      tbl.push_back(idle_(2'd0, 8'h00));
      tbl.push_back(run_());
      tbl.push_back(in_(2'd1, 8'h11));
      tbl.push_back(in_(2'd1, 8'h12));
      tbl.push_back(in_(2'd2, 8'h21));
      tbl.push_back(in_(2'd2, 8'h22));
      tbl.push_back(in_(2'd2, 8'h23));
      tbl.push_back(wr_(2'd2, 8'h24, 12'd256, 32'h24232221));
      tbl.push_back(in_(2'd1, 8'h13));
      tbl.push_back(wr_(2'd1, 8'h14, 12'd0, 32'h14131211));
      tbl.push_back(in_(2'd3, 8'h00));
      tbl.push_back(in_(2'd0, 8'h00));
      tbl.push_back(done_(2'd0, 8'h00));
      tbl.push_back(idle_(2'd0, 8'h00));
      tbl.push_back(run_());
      tbl.push_back(in_(2'd1, 8'h0A));
      tbl.push_back(in_(2'd1, 8'h0B));
      tbl.push_back(in_(2'd1, 8'h0C));
      tbl.push_back(in_(2'd2, 8'h0D));
      tbl.push_back(wr_(2'd3, 8'h00, 12'd0, 32'h000C0B0A));
      tbl.push_back(wr_(2'd1, 8'hEE, 12'd256, 32'h0000000D));
      tbl.push_back(done_(2'd2, 8'hFF));
      tbl.push_back(idle_(2'd1, 8'h77));
      tbl.push_back(idle_(2'd0, 8'h00));
      tbl.push_back(run_());
      tbl.push_back(in_(2'd3, 8'h00));
      tbl.push_back(in_(2'd0, 8'h00));
      tbl.push_back(done_(2'd0, 8'h00));
      tbl.push_back(idle_(2'd0, 8'h00));

      // Reset state, then a reset landing mid-RUN with three bytes buffered.
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_b = 1'b1;
      apply(run_(), "rst run");
      apply(in_(2'd1, 8'hA1), "rst b0");
      apply(in_(2'd1, 8'hA2), "rst b1");
      apply(in_(2'd1, 8'hA3), "rst b2");
      reset_b = 1'b0;
      #1;
      check_all_zero("midrun reset");
      valid_in = 2'd1;
      step();
      check_all_zero("held reset");
      reset_b = 1'b1;
      apply(run_(), "post run");
      apply(in_(2'd1, 8'hFF), "post b0");
      apply(in_(2'd1, 8'hFE), "post b1");
      apply(in_(2'd1, 8'hFD), "post b2");
      apply(wr_(2'd1, 8'hFC, 12'd0, 32'hFCFDFEFF), "post b3");
      apply(in_(2'd3, 8'h00), "post eol");
      apply(in_(2'd0, 8'h00), "post f0");
      apply(done_(2'd0, 8'h00), "post done");
      apply(idle_(2'd0, 8'h00), "post idle");

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // Overflow on the two-word instance: third region-0 write sets the sticky flag.
      apply(run_(), "ov run");
      for (int i = 1; i <= 12; i++) begin
         if (i % 4 == 0)
            v = wr_(2'd1, 8'(i), 12'(i / 4 - 1), {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
         else
            v = in_(2'd1, 8'(i));
         v.ovf2 = (i == 12);
         apply(v, $sformatf("ov b%0d", i));
      end
      v = in_(2'd3, 8'h00);   v.ovf2 = 1'b1; apply(v, "ov eol");
      v = in_(2'd0, 8'h00);   v.ovf2 = 1'b1; apply(v, "ov f0");
      v = done_(2'd0, 8'h00); v.ovf2 = 1'b1; apply(v, "ov done");
      v = idle_(2'd0, 8'h00); v.ovf2 = 1'b1; apply(v, "ov idle");
      apply(run_(), "ov restart");
      apply(in_(2'd3, 8'h00), "ov r eol");
      apply(in_(2'd0, 8'h00), "ov r f0");
      apply(done_(2'd0, 8'h00), "ov r done");
      apply(idle_(2'd0, 8'h00), "ov r idle");

      // Randomized layers; the first is long enough to overflow region 0 of the main instance.
      for (int l = 0; l < 30; l++) begin
         vecs.delete();
         if (l == 0) gen_layer(1100, 95);
         else        gen_layer($urandom_range(0, 40), 40);
         for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("L%0d.%0d", l, i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
